fp_wb_sched: RTL
================

Name: fp_wb_sched

Overview:
- Write-back scheduler and scoreboard for the FP register file's single write port.
- Arbitrates round-robin among N_REQ FP result producers (e.g. FP load, FPU pipe, div/sqrt) and drives fp_we / rd_reg / fp_wdata from a registered output stage.
- Tracks pending FP destinations in a 32-bit busy scoreboard and reports RAW and WAW hazards to decode.

Parameters:
- N_REQ, 3, number of result requesters (2..8).
- XLEN, 32, FP data width; must match the register file's data width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset: synchronous and active-high; all state cleared on the clock edge where rst=1.
- req_valid  input  N_REQ  requester i has a result.
- req_ready  output  N_REQ  grant; transfer when valid&ready.
- req_rd  input  N_REQ*5  destination of requester i, packed, slice i = [5i+4:5i].
- req_data  input  N_REQ*XLEN  result of requester i, packed.
- issue_valid  input  1  decode issues an instruction writing an FP register.
- issue_rd  input  5  its destination.
- issue_block  output  1  busy[issue_rd]; WAW stall.
- rs_use  input  3  bit k set if rs(k+1) is an FP source.
- rs1_reg, rs2_reg, rs3_reg  input  5 each  decode source indices.
- hazard  output  1  RAW stall.
- busy  output  32  scoreboard bits.
- fp_we  output  1  to register file write enable.
- rd_reg  output  5  to register file write address.
- fp_wdata  output  XLEN  to register file write data.

Behaviour:
- Reset values: fp_we=0, rd_reg=0, fp_wdata=0, busy=0, rr_ptr=0. req_ready=0 during reset.
- Arbitration (combinational):
  - Grant goes to the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod N_REQ.
  - req_ready is one-hot or zero. At most one transfer per cycle.
  - req_ready never depends on anything except req_valid and rr_ptr; the port is never back-pressured.
- rr_ptr update on a transfer from i: rr_ptr <= (i+1) mod N_REQ. Otherwise it holds.
- Output stage, 1-cycle latency:
  - Transfer in cycle T → in cycle T+1, fp_we=1, rd_reg=req_rd[i], fp_wdata=req_data[i].
  - No transfer → fp_we=0; rd_reg and fp_wdata hold their previous values.
  - The regfile commits at the end of T+1.
- Scoreboard:
  - set(r) = issue_valid & (issue_rd==r) & (r!=0).
  - clr(r) = fp_we & (rd_reg==r).
  - busy[r] <= set(r) ? 1 : (clr(r) ? 0 : busy[r]). Set wins over clear in the same cycle: the newer producer owns the register.
  - busy[0] is always 0, because f0 writes are dropped by the register file.
  - Producers with rd=0 are still granted and drive fp_we; this is harmless.
- issue_block = busy[issue_rd] & (issue_rd!=0).
  - Decode must not assert issue_valid while issue_block=1.
  - If it does anyway, busy stays set; no error flag is raised.
- hazard = OR over k of (rs_use[k] & busy[rs(k+1)_reg]). It is purely combinational from busy. A clear in cycle T+1 is visible as hazard=0 in T+2, when regfile read data is valid.
- Reset mid-operation: a pending output-stage write is discarded (fp_we=0 next cycle), and all busy bits are cleared.

Optional Feature:
- Macro: FP_WB_BYPASS_EN.
- Defined:
  - Adds output port fwd_hit [2:0].
  - fwd_hit[k] = fp_we & rs_use[k] & (rd_reg==rs(k+1)_reg) & (rd_reg!=0).
  - hazard suppresses source k when fwd_hit[k]=1; decode then takes fp_wdata in place of the regfile data.
  - This saves one stall cycle per RAW dependency.
- Undefined: no fwd_hit port, and hazard behaves exactly as above.

Test Plan:
- Reset: assert rst 2 cycles with all req_valid=1 → req_ready=0, fp_we=0, busy=0. After release, first grant goes to requester 0.
- Round-robin: req_valid=3'b111 held for 6 cycles with rd=1,2,3 → grants 0,1,2,0,1,2. fp_we=1 from cycle 2 on, rd_reg sequence 1,2,3,1,2,3 one cycle after each grant.
- Scoreboard RAW: issue rd=5. Next cycle rs1_reg=5, rs_use=001 → hazard=1. Requester 1 returns rd=5, data=0x3F800000 → fp_we in next cycle. hazard drops the cycle after fp_we (T+2).
- Set/clear collision: fp_we=1, rd_reg=7 in the same cycle as issue_valid=1, issue_rd=7 → busy[7]=1 afterwards, issue_block for rd 7 stays 1.
- rd 0: issue_valid with issue_rd=0 → busy unchanged, issue_block=0. A requester with rd=0 is granted and fp_we=1, rd_reg=0.
- Bypass (FP_WB_BYPASS_EN): busy[9]=1, output stage writing rd 9, rs2_reg=9, rs_use=010 → fwd_hit=010 and hazard=0. Without the macro, hazard=1 in that cycle.

Source files
------------

// File: rtl/fp_wb_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : fp_wb_sched_if
//  Description : Result-producer bus for the FP write-back scheduler.
//                Carries the per-requester valid/ready handshake together
//                with the packed destination indices and result data.
//                Slice i of req_rd is [5i+4:5i]. Slice i of req_data is
//                [XLEN*i+XLEN-1:XLEN*i].
//  Modports    : master - result producers (drive valid/rd/data)
//                slave  - scheduler (drives ready)
//  Revision    : 1.0 - initial release
// ============================================================================
interface fp_wb_sched_if #(
    parameter int N_REQ = 3,
    parameter int XLEN  = 32
);
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ*5-1:0]    req_rd;
    logic [N_REQ*XLEN-1:0] req_data;

    modport master (
        output req_valid,
        output req_rd,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_rd,
        input  req_data,
        output req_ready
    );
endinterface
`default_nettype wire

// File: rtl/fp_wb_sched.sv
`default_nettype none
// ============================================================================
//  Module      : fp_wb_sched
//  Description : Write-back scheduler and busy scoreboard for the single
//                write port of the FP register file. Round-robin arbitration
//                among N_REQ result producers, registered write stage, and
//                RAW/WAW hazard reporting to decode.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                req_bus (slave)   - producer valid/ready/rd/data
//                issue_valid/_rd   - decode issue of an FP-writing instr
//                issue_block       - WAW stall (destination still busy)
//                rs_use, rs1..3    - decode FP source usage and indices
//                hazard            - RAW stall
//                busy              - 32-bit scoreboard
//                fp_we/rd_reg/fp_wdata - register file write port
//                fwd_hit           - per-source forward hit (bypass build)
//  Options     : `define FP_WB_BYPASS_EN adds fwd_hit and lets a source that
//                matches the in-flight write take fp_wdata instead of
//                stalling.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_wb_sched #(
    parameter int N_REQ = 3,
    parameter int XLEN  = 32
) (
    input  wire logic            clk,
    input  wire logic            rst,
    fp_wb_sched_if.slave         req_bus,
    input  wire logic            issue_valid,
    input  wire logic [4:0]      issue_rd,
    output logic                 issue_block,
    input  wire logic [2:0]      rs_use,
    input  wire logic [4:0]      rs1_reg,
    input  wire logic [4:0]      rs2_reg,
    input  wire logic [4:0]      rs3_reg,
    output logic                 hazard,
    output logic [31:0]          busy,
`ifdef FP_WB_BYPASS_EN
    output logic [2:0]           fwd_hit,
`endif
    output logic                 fp_we,
    output logic [4:0]           rd_reg,
    output logic [XLEN-1:0]      fp_wdata
);

    localparam int                 c_PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(N_REQ - 1);
    localparam logic [c_PTR_W:0]   c_NREQ  = (c_PTR_W + 1)'(N_REQ);

    logic [c_PTR_W-1:0] r_rr_ptr;
    logic               r_fp_we;
    logic [4:0]         r_rd_reg;
    logic [XLEN-1:0]    r_fp_wdata;
    logic [31:0]        r_busy;

    logic [N_REQ-1:0]   w_grant;
    logic [c_PTR_W-1:0] w_gidx;
    logic               w_found;
    logic               w_xfer;
    logic [4:0]         w_sel_rd;
    logic [XLEN-1:0]    w_sel_data;
    logic [31:0]        w_set;
    logic [31:0]        w_clr;
    logic [31:0]        w_busy_nxt;
    logic [2:0]         w_src_hit;
    logic [2:0]         w_fwd;

    // Round-robin search starting at r_rr_ptr; first valid requester wins.
    always_comb begin
        logic [c_PTR_W:0] v_idx;
        w_grant = '0;
        w_gidx  = '0;
        w_found = 1'b0;
        v_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            v_idx = {1'b0, r_rr_ptr} + (c_PTR_W + 1)'(k);
            if (v_idx >= c_NREQ) begin
                v_idx = v_idx - c_NREQ;
            end
            if (!w_found && req_bus.req_valid[v_idx[c_PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_gidx  = v_idx[c_PTR_W-1:0];
            end
        end
        if (w_found) begin
            w_grant[w_gidx] = 1'b1;
        end
    end

    // Grant is one-hot, so an OR-mux selects the winner's payload.
    always_comb begin
        w_sel_rd   = '0;
        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_rd   = w_sel_rd   | req_bus.req_rd[i*5 +: 5];
                w_sel_data = w_sel_data | req_bus.req_data[i*XLEN +: XLEN];
            end
        end
    end

    assign req_bus.req_ready = rst ? '0 : w_grant;
    assign w_xfer            = w_found & ~rst;

    // Scoreboard: a new issue to a register overrides a retiring write to
    // the same register, since the newer producer now owns it. f0 never
    // becomes busy because the register file drops its writes.
    always_comb begin
        w_set      = issue_valid ? (32'd1 << issue_rd) : 32'd0;
        w_clr      = r_fp_we     ? (32'd1 << r_rd_reg) : 32'd0;
        w_busy_nxt = (r_busy & ~w_clr) | w_set;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_fp_we    <= 1'b0;
            r_rd_reg   <= '0;
            r_fp_wdata <= '0;
            r_busy     <= '0;
        end else begin
            r_fp_we <= w_xfer;
            r_busy  <= w_busy_nxt;
            if (w_xfer) begin
                r_rr_ptr   <= (w_gidx == c_LAST) ? '0 : w_gidx + 1'b1;
                r_rd_reg   <= w_sel_rd;
                r_fp_wdata <= w_sel_data;
            end
        end
    end

    // Hazards. The write retiring this cycle still shows busy, so without
    // forwarding the dependent instruction reads the regfile one cycle later.
    always_comb begin
        w_src_hit[0] = rs_use[0] & r_busy[rs1_reg];
        w_src_hit[1] = rs_use[1] & r_busy[rs2_reg];
        w_src_hit[2] = rs_use[2] & r_busy[rs3_reg];
`ifdef FP_WB_BYPASS_EN
        w_fwd[0] = r_fp_we & rs_use[0] & (r_rd_reg == rs1_reg) & (r_rd_reg != 5'd0);
        w_fwd[1] = r_fp_we & rs_use[1] & (r_rd_reg == rs2_reg) & (r_rd_reg != 5'd0);
        w_fwd[2] = r_fp_we & rs_use[2] & (r_rd_reg == rs3_reg) & (r_rd_reg != 5'd0);
`else
        w_fwd = 3'b000;
`endif
    end

    assign hazard      = |(w_src_hit & ~w_fwd);
    assign issue_block = r_busy[issue_rd] & (issue_rd != 5'd0);
    assign busy        = r_busy;
    assign fp_we       = r_fp_we;
    assign rd_reg      = r_rd_reg;
    assign fp_wdata    = r_fp_wdata;
`ifdef FP_WB_BYPASS_EN
    assign fwd_hit     = w_fwd;
`endif

endmodule
`default_nettype wire
